// File: rtl/loop_countdown.sv
// Two-digit BCD down-counter (99..00) with preset load, start/pause control,
// a programmable prescaler and terminal-count signalling (done / done_pulse).
module loop_countdown #(
  parameter int TICK_DIV = 1,   // clock cycles per count step while running
  parameter int DIV_W    = 16   // prescaler width, must hold TICK_DIV-1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] out1,
  output logic [3:0] out0,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Prescaler terminal value: a step fires when the divider reaches it.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [3:0]       tens_reg, tens_next;
  logic [3:0]       ones_reg, ones_next;
  logic             running_reg, done_reg, done_pulse_reg;
  logic             done_pulse_next;

  // Preset digits above 9 are not valid BCD; saturate them to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // State, value, prescaler and output flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      tens_reg       <= 4'd0;
      ones_reg       <= 4'd0;
      running_reg    <= 1'b0;
      done_reg       <= 1'b0;
      done_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      tens_reg       <= tens_next;
      ones_reg       <= ones_next;
      running_reg    <= (state_next == RUN);
      done_reg       <= (state_next == DONE);
      done_pulse_reg <= done_pulse_next;
    end
  end

  // Next-state logic: load wins over start, start over pause, pause over step.
  always_comb begin
    state_next      = state_reg;
    div_cnt_next    = div_cnt_reg;
    tens_next       = tens_reg;
    ones_next       = ones_reg;
    done_pulse_next = 1'b0;

    if (load) begin
      tens_next    = clamp_bcd(load_tens);
      ones_next    = clamp_bcd(load_ones);
      state_next   = IDLE;
      div_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (tens_reg == 4'd0 && ones_reg == 4'd0) begin
              state_next      = DONE;
              done_pulse_next = 1'b1;
            end else begin
              state_next   = RUN;
              div_cnt_next = '0;
            end
          end
        end

        RUN: begin
          // start is a no-op here; pause freezes value and prescaler phase.
          if (pause) begin
            state_next = PAUSE;
          end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
            if (ones_reg != 4'd0) begin
              ones_next = ones_reg - 4'd1;
            end else begin
              ones_next = 4'd9;
              tens_next = tens_reg - 4'd1;
            end
            // Stepping out of 01 lands on 00: terminal count reached.
            if (tens_reg == 4'd0 && ones_reg == 4'd1) begin
              state_next      = DONE;
              done_pulse_next = 1'b1;
            end
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
          end
        end

        PAUSE: begin
          // Resume keeps the held divider so the step phase is preserved.
          if (start) begin
            state_next = RUN;
          end
        end

        DONE: begin
          // Only load or reset leaves DONE.
          state_next = DONE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign out1       = tens_reg;
  assign out0       = ones_reg;
  assign running    = running_reg;
  assign done       = done_reg;
  assign done_pulse = done_pulse_reg;

endmodule

// File: tb/tb_loop_countdown.sv
// Directed bench for loop_countdown: one instance with TICK_DIV=1, one with
// TICK_DIV=4, both driven by the same control inputs.
module tb_loop_countdown;

  logic       clk = 1'b0;
  logic       resetn;
  logic       load, start, pause;
  logic [3:0] load_tens, load_ones;

  logic [3:0] d1_out1, d1_out0, d4_out1, d4_out0;
  logic       d1_running, d1_done, d1_pulse;
  logic       d4_running, d4_done, d4_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation vectors: {tens, ones, running, done, done_pulse}
  logic [10:0] d1_obs, d4_obs, exp_v;
  assign d1_obs = {d1_out1, d1_out0, d1_running, d1_done, d1_pulse};
  assign d4_obs = {d4_out1, d4_out0, d4_running, d4_done, d4_pulse};

  always #5 clk = ~clk;

  loop_countdown #(.TICK_DIV(1), .DIV_W(16)) dut1 (
    .clk(clk), .resetn(resetn), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .start(start), .pause(pause),
    .out1(d1_out1), .out0(d1_out0), .running(d1_running),
    .done(d1_done), .done_pulse(d1_pulse)
  );

  loop_countdown #(.TICK_DIV(4), .DIV_W(16)) dut4 (
    .clk(clk), .resetn(resetn), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .start(start), .pause(pause),
    .out1(d4_out1), .out0(d4_out0), .running(d4_running),
    .done(d4_done), .done_pulse(d4_pulse)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    tick();
    load = 1'b0;
    $display("load tens=%h ones=%h", t, o);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("start");
  endtask

  task automatic test_reset();
    resetn = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_tens = 4'd0; load_ones = 4'd0;
    tick(); tick();
    exp_v = 11'd0;
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL reset_d1: got %h expected %h", d1_obs, exp_v); end
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL reset_d4: got %h expected %h", d4_obs, exp_v); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_count_tick1();
    int v;
    do_load(4'd2, 4'd5);
    exp_v = {4'd2, 4'd5, 1'b0, 1'b0, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL count_load: got %h expected %h", d1_obs, exp_v); end
    do_start();
    exp_v = {4'd2, 4'd5, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL count_run: got %h expected %h", d1_obs, exp_v); end
    for (int i = 1; i <= 6; i++) begin
      tick();
      v = 25 - i;
      exp_v = {4'(v / 10), 4'(v % 10), 1'b1, 1'b0, 1'b0};
      $display("step d1 value %h%h", d1_out1, d1_out0);
      n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL count_step%0d: got %h expected %h", i, d1_obs, exp_v); end
    end
  endtask

  task automatic test_tick4();
    int v;
    do_load(4'd0, 4'd3);
    do_start();
    exp_v = {4'd0, 4'd3, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL div4_run: got %h expected %h", d4_obs, exp_v); end
    for (int t = 1; t <= 13; t++) begin
      tick();
      v = (t >= 12) ? 0 : 3 - t / 4;
      exp_v = {4'd0, 4'(v), (t < 12), (t >= 12), (t == 12)};
      $display("cycle %0d d4 value %h%h done_pulse %b", t, d4_out1, d4_out0, d4_pulse);
      n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL div4_cycle%0d: got %h expected %h", t, d4_obs, exp_v); end
    end
  endtask

  task automatic test_pause();
    do_load(4'd1, 4'd0);
    do_start();
    for (int t = 1; t <= 4; t++) tick();
    exp_v = {4'd0, 4'd9, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_first_step: got %h expected %h", d4_obs, exp_v); end
    tick();                         // prescaler now one cycle into its period
    pause = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_v = {4'd0, 4'd9, 1'b0, 1'b0, 1'b0};
      n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_hold%0d: got %h expected %h", k, d4_obs, exp_v); end
    end
    pause = 1'b0;
    do_start();
    exp_v = {4'd0, 4'd9, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_resume: got %h expected %h", d4_obs, exp_v); end
    tick(); tick();
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_phase_early: got %h expected %h", d4_obs, exp_v); end
    tick();
    exp_v = {4'd0, 4'd8, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_phase_08: got %h expected %h", d4_obs, exp_v); end
    tick(); tick(); tick();
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_hold_08: got %h expected %h", d4_obs, exp_v); end
    tick();
    exp_v = {4'd0, 4'd7, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL pause_step_07: got %h expected %h", d4_obs, exp_v); end
  endtask

  task automatic test_zero_start();
    do_load(4'd0, 4'd0);
    exp_v = 11'd0;
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL zero_load: got %h expected %h", d1_obs, exp_v); end
    do_start();
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL zero_done_pulse: got %h expected %h", d1_obs, exp_v); end
    tick();
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL zero_done_level: got %h expected %h", d1_obs, exp_v); end
    for (int k = 1; k <= 3; k++) begin
      do_start();
      tick();
      n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL zero_restart%0d: got %h expected %h", k, d1_obs, exp_v); end
    end
    do_load(4'd0, 4'd5);
    exp_v = {4'd0, 4'd5, 1'b0, 1'b0, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL zero_reload: got %h expected %h", d1_obs, exp_v); end
  endtask

  task automatic test_clamp_and_full();
    int v;
    do_load(4'hF, 4'hA);
    exp_v = {4'd9, 4'd9, 1'b0, 1'b0, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL clamp: got %h expected %h", d1_obs, exp_v); end
    load = 1'b1; start = 1'b1; load_tens = 4'd4; load_ones = 4'd2;
    tick();
    load = 1'b0; start = 1'b0;
    $display("load+start tens=4 ones=2");
    exp_v = {4'd4, 4'd2, 1'b0, 1'b0, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL load_start: got %h expected %h", d1_obs, exp_v); end
    tick();
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL load_start_idle: got %h expected %h", d1_obs, exp_v); end
    do_load(4'd9, 4'd9);
    do_start();
    for (int i = 1; i <= 99; i++) begin
      tick();
      v = 99 - i;
      exp_v = {4'(v / 10), 4'(v % 10), (i < 99), (i == 99), (i == 99)};
      n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL full_step%0d: got %h expected %h", i, d1_obs, exp_v); end
    end
    $display("full count d1 value %h%h done %b", d1_out1, d1_out0, d1_done);
    tick();
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL full_done_hold: got %h expected %h", d1_obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    do_load(4'd5, 4'd0);
    do_start();
    tick(); tick(); tick();
    exp_v = {4'd4, 4'd7, 1'b1, 1'b0, 1'b0};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL mid_47: got %h expected %h", d1_obs, exp_v); end
    #3 resetn = 1'b0;
    #1;
    $display("async reset asserted mid-count");
    exp_v = 11'd0;
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL mid_reset_d1: got %h expected %h", d1_obs, exp_v); end
    n_checks++; if (d4_obs !== exp_v) begin n_fail++; $display("FAIL mid_reset_d4: got %h expected %h", d4_obs, exp_v); end
    #1 resetn = 1'b1;
    tick();
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL mid_release: got %h expected %h", d1_obs, exp_v); end
    do_start();
    exp_v = {4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    n_checks++; if (d1_obs !== exp_v) begin n_fail++; $display("FAIL mid_start_done: got %h expected %h", d1_obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_count_tick1();
    test_tick4();
    test_pause();
    test_zero_start();
    test_clamp_and_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
